// File: rtl/dac_update_arbiter.sv
// dac_update_arbiter
//   Shares one DAC SPI main link (18-bit frames: power_state + sample) between
//   NUM_REQ requesters. Round-robin grant, latches the winning word, pulses
//   spi_load, follows the transfer through spi_csb, enforces a minimum csb-high
//   gap between frames, and flags a link that never starts shifting.
//
// Ports
//   sys_clk, rst          clock; asynchronous active-high reset
//   req_valid/data/pwr    per-requester request; data at [i*WORD_WIDTH +: WORD_WIDTH],
//                         power_state at [i*2 +: 2]
//   req_ready             one-hot accept pulse (transfer = valid & ready)
//   half_speed_cfg        SCLK rate captured at grant (0 full, 1 half)
//   spi_load              one-cycle load strobe to the SPI main
//   spi_speed_select      speed for the frame in flight
//   spi_parallel_in       latched sample
//   spi_power_state       latched power_state
//   spi_csb               SPI main chip select, low while shifting
//   busy                  high whenever the arbiter is not idle
//   grant_id              index of the last granted requester
//   start_err / err_clr   sticky start-timeout flag and its synchronous clear
module dac_update_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int WORD_WIDTH    = 16,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 4
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]          req_pwr,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          half_speed_cfg,
  output logic                          spi_load,
  output logic                          spi_speed_select,
  output logic [WORD_WIDTH-1:0]         spi_parallel_in,
  output logic [1:0]                    spi_power_state,
  input  logic                          spi_csb,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          start_err,
  input  logic                          err_clr
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int RW    = IDX_W + 1;
  localparam int TW    = $clog2(START_TIMEOUT + 1);
  localparam int GW    = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  // Everything the SPI main needs for one frame, captured together at grant.
  typedef struct packed {
    logic                  speed;
    logic [1:0]            pwr;
    logic [WORD_WIDTH-1:0] word;
  } frame_t;

  state_t state, state_nxt;
  frame_t frame_q;

  logic [IDX_W-1:0] rr_ptr;   // first index searched at the next grant
  logic [TW-1:0]    to_cnt;
  logic [GW-1:0]    gap_cnt;

  logic [NUM_REQ-1:0][WORD_WIDTH-1:0] lane_word;
  logic [NUM_REQ-1:0][1:0]            lane_pwr;
  logic [NUM_REQ-1:0][IDX_W-1:0]      lane_rank;

  logic             found;
  logic [IDX_W-1:0] win;
  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0] rr_next;
  logic             gap_full, grant_go, to_hit, gap_hit;

  // Per-lane unpacking and priority rank: rank 0 is the lane at rr_ptr,
  // increasing upward with wrap-around.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    localparam logic [RW-1:0] LI = RW'(i);
    logic [RW-1:0] ptr_w;
    assign ptr_w        = {1'b0, rr_ptr};
    assign lane_word[i] = req_data[i*WORD_WIDTH +: WORD_WIDTH];
    assign lane_pwr[i]  = req_pwr[i*2 +: 2];
    assign lane_rank[i] = (LI >= ptr_w) ? IDX_W'(LI - ptr_w)
                                        : IDX_W'(LI + RW'(NUM_REQ) - ptr_w);
  end

  // Winner = valid lane with the smallest rank.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && lane_rank[i] == IDX_W'(k)) begin
          found = 1'b1;
          win   = IDX_W'(i);
        end
      end
    end
    win_oh[win] = 1'b1;
  end

  assign rr_next  = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  // gap_cnt saturates at GAP_CYCLES while idle, so a grant right after reset
  // still waits for a full csb-high gap; leaving GAP it already sits at full.
  assign gap_full = (gap_cnt == GW'(GAP_CYCLES));
  assign grant_go = (state == S_IDLE) && spi_csb && gap_full && found;
  assign to_hit   = (state == S_WAIT_START) && spi_csb &&
                    (to_cnt == TW'(START_TIMEOUT - 1));
  assign gap_hit  = (state == S_GAP) && spi_csb &&
                    (gap_cnt == GW'(GAP_CYCLES - 1));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:       if (grant_go) state_nxt = S_LOAD;
      S_LOAD:       state_nxt = S_WAIT_START;
      S_WAIT_START: begin
        if (!spi_csb)    state_nxt = S_WAIT_DONE;
        else if (to_hit) state_nxt = S_GAP;   // word dropped, no retry
      end
      S_WAIT_DONE:  if (spi_csb) state_nxt = S_GAP;
      S_GAP:        if (gap_hit) state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
      req_ready <= '0;
      spi_load  <= 1'b0;
      busy      <= 1'b0;
      grant_id  <= '0;
      start_err <= 1'b0;
      frame_q   <= '0;
    end else begin
      req_ready <= grant_go ? win_oh : '0;
      spi_load  <= (state == S_LOAD);
      busy      <= (state_nxt != S_IDLE);

      if (grant_go) begin
        grant_id <= win;
        rr_ptr   <= rr_next;
        frame_q  <= '{speed: half_speed_cfg, pwr: lane_pwr[win], word: lane_word[win]};
      end

      to_cnt <= (state == S_WAIT_START && spi_csb) ? to_cnt + 1'b1 : '0;

      if (state == S_IDLE || state == S_GAP)
        gap_cnt <= !spi_csb ? '0 : (gap_full ? gap_cnt : gap_cnt + 1'b1);
      else
        gap_cnt <= '0;

      // Timeout set takes priority over a same-cycle clear.
      if (to_hit)       start_err <= 1'b1;
      else if (err_clr) start_err <= 1'b0;
    end
  end

  assign spi_speed_select = frame_q.speed;
  assign spi_power_state  = frame_q.pwr;
  assign spi_parallel_in  = frame_q.word;

endmodule

// File: tb/tb_dac_update_arbiter.sv
module tb_dac_update_arbiter;
  localparam int N   = 4;
  localparam int W   = 16;
  localparam int GAP = 2;
  localparam int TO  = 4;

  logic             sys_clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     v = '0;
  logic [W-1:0]     d [N];
  logic [1:0]       p [N];
  logic [N*W-1:0]   req_data;
  logic [N*2-1:0]   req_pwr;
  logic [N-1:0]     req_ready;
  logic             half_speed_cfg = 1'b0;
  logic             spi_load, spi_speed_select;
  logic [W-1:0]     spi_parallel_in;
  logic [1:0]       spi_power_state;
  logic             spi_csb = 1'b1;
  logic             busy;
  logic [1:0]       grant_id;
  logic             start_err;
  logic             err_clr = 1'b0;

  always #5 sys_clk = ~sys_clk;

  always_comb begin
    req_data = '0;
    req_pwr  = '0;
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W] = d[i];
      req_pwr[i*2 +: 2]  = p[i];
    end
  end

  dac_update_arbiter #(.NUM_REQ(N), .WORD_WIDTH(W), .GAP_CYCLES(GAP), .START_TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .rst(rst), .req_valid(v), .req_data(req_data), .req_pwr(req_pwr),
    .req_ready(req_ready), .half_speed_cfg(half_speed_cfg), .spi_load(spi_load),
    .spi_speed_select(spi_speed_select), .spi_parallel_in(spi_parallel_in),
    .spi_power_state(spi_power_state), .spi_csb(spi_csb), .busy(busy),
    .grant_id(grant_id), .start_err(start_err), .err_clr(err_clr)
  );

  // ---------------- behavioural reference ----------------
  // A frame is described by flags: word loaded, link started, closing gap.
  bit [N-1:0] e_ready;
  bit         e_load, e_busy, e_err, e_spd;
  bit [W-1:0] e_data;
  bit [1:0]   e_pwr;
  int         e_gid, rr, run, nostart, close_run;
  bit         loaded, started, closing;

  always @(posedge sys_clk or posedge rst) begin
    int g;
    bit set_err;
    if (rst) begin
      e_ready = '0; e_load = 0; e_busy = 0; e_err = 0; e_spd = 0;
      e_data = '0; e_pwr = '0; e_gid = 0; rr = 0; run = 0;
      nostart = 0; close_run = 0; loaded = 0; started = 0; closing = 0;
    end else begin
      set_err = 0;
      e_ready = '0;
      e_load  = 0;
      if (!e_busy) begin
        if (spi_csb && run >= GAP && v != 0) begin
          g = -1;
          for (int k = 0; k < N; k++)
            if (g < 0 && v[(rr + k) % N]) g = (rr + k) % N;
          e_ready[g] = 1; e_data = d[g]; e_pwr = p[g]; e_spd = half_speed_cfg;
          e_gid = g; rr = (g + 1) % N;
          e_busy = 1; loaded = 0; started = 0; closing = 0;
        end
        run = spi_csb ? ((run < GAP) ? run + 1 : GAP) : 0;
      end else if (!loaded) begin
        e_load = 1; loaded = 1; nostart = 0;
      end else if (closing) begin
        close_run = spi_csb ? close_run + 1 : 0;
        if (close_run >= GAP) begin e_busy = 0; run = GAP; end
      end else if (started) begin
        if (spi_csb) begin closing = 1; close_run = 0; end
      end else if (!spi_csb) begin
        started = 1;
      end else begin
        nostart++;
        if (nostart >= TO) begin set_err = 1; closing = 1; close_run = 0; end
      end
      if (set_err)      e_err = 1;
      else if (err_clr) e_err = 0;
    end
  end

  // ---------------- bench state ----------------
  int errors = 0, checks = 0, cyc = 0;
  int spi_cnt = 0, last_len = 0, last_load_cyc = -1, csb_rise_cyc = 0, load_cnt = 0;
  bit spi_dead = 0, frame_spd = 0, rand_mode = 0;
  bit [N-1:0] last_ready = '0, refill = '0;
  int ready_cnt [N];
  int grant_log [$];
  bit speed_log [$];
  logic [17:0] frame_log [$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Negedge: compare DUT against the model, then act as the SPI main.
  task automatic negedge_work();
    chk("req_ready", req_ready, e_ready);
    chk("spi_load", spi_load, e_load);
    chk("busy", busy, e_busy);
    chk("start_err", start_err, e_err);
    chk("grant_id", grant_id, e_gid);
    chk("speed_select", spi_speed_select, e_spd);
    chk("parallel_in", spi_parallel_in, e_data);
    chk("power_state", spi_power_state, e_pwr);
    chk("ready_onehot", $countones(req_ready) <= 1, 1);
    for (int i = 0; i < N; i++)
      if (req_ready[i]) begin ready_cnt[i]++; grant_log.push_back(i); end
    if (spi_cnt > 0) begin
      if (busy && !rst) chk("speed_hold", spi_speed_select, frame_spd);
      spi_cnt--;
      if (spi_cnt == 0) begin spi_csb = 1'b1; csb_rise_cyc = cyc; end
    end
    if (spi_load) begin
      load_cnt++;
      chk("load_on_idle_link", spi_cnt, 0);
      if (last_load_cyc >= 0 && last_len > 0)
        chk("load_spacing", (cyc - last_load_cyc) >= (2 + last_len + GAP), 1);
      frame_log.push_back({spi_power_state, spi_parallel_in});
      speed_log.push_back(spi_speed_select);
      last_load_cyc = cyc;
      if (!spi_dead) begin
        last_len  = spi_speed_select ? 36 : 18;
        spi_csb   = 1'b0;
        spi_cnt   = last_len;
        frame_spd = spi_speed_select;
      end else last_len = 0;
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    negedge_work();
    @(posedge sys_clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++)
      if (last_ready[i]) begin
        if (refill[i]) begin d[i] = W'($urandom); p[i] = 2'($urandom); end
        else v[i] = 1'b0;
      end
    last_ready = req_ready;
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i]) begin
          if ($urandom_range(0, 7) == 0) begin
            v[i] = 1'b1; d[i] = W'($urandom); p[i] = 2'($urandom);
          end
        end else if (!req_ready[i] && $urandom_range(0, 29) == 0) v[i] = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) half_speed_cfg = ~half_speed_cfg;
      err_clr = ($urandom_range(0, 15) == 0);
      if (!spi_dead && $urandom_range(0, 299) == 0) spi_dead = 1;
      else if (spi_dead && $urandom_range(0, 19) == 0) spi_dead = 0;
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_spi_load", spi_load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start_err", start_err, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_parallel_in", spi_parallel_in, 0);
    chk("rst_speed", spi_speed_select, 0);
    repeat (2) tick();
    rst = 1'b0;
    last_ready = '0;
  endtask

  // kind: 0 load, 1 busy low, 2 start_err high, 3 csb low
  task automatic wait_for(input int kind, input int budget, input string name);
    int n;
    bit hit;
    n = 0; hit = 0;
    while (!hit && n < budget) begin
      tick(); n++;
      case (kind)
        0: hit = spi_load;
        1: hit = !busy;
        2: hit = start_err;
        default: hit = !spi_csb;
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_%s: condition not reached within %0d cycles", name, budget);
    end
  endtask

  initial begin
    int l0, r1, t_err;
    for (int i = 0; i < N; i++) begin d[i] = '0; p[i] = '0; ready_cnt[i] = 0; end
    repeat (3) tick();
    reset_pulse();

    // 1: single requester, literal frame and busy-fall timing
    v[0] = 1; d[0] = 16'hA5C3; p[0] = 2'b00;
    wait_for(0, 20, "t1_load");
    chk("t1_grant_id", grant_id, 0);
    tick();
    chk("t1_frame", frame_log[$], 18'h0A5C3);
    wait_for(1, 100, "t1_idle");
    chk("t1_busy_fall", cyc - csb_rise_cyc, GAP + 1);
    chk("t1_ready_pulses", ready_cnt[0], 1);

    // 2: all requesters continuously valid from reset
    reset_pulse();
    grant_log.delete();
    v = '1; refill = '1;
    for (int n = 0; n < 400 && grant_log.size() < 5; n++) tick();
    chk("t2_grants", grant_log.size() >= 5, 1);
    if (grant_log.size() >= 5) begin
      chk("t2_g0", grant_log[0], 0); chk("t2_g1", grant_log[1], 1);
      chk("t2_g2", grant_log[2], 2); chk("t2_g3", grant_log[3], 3);
      chk("t2_g4", grant_log[4], 0);
    end
    refill = '0; v = '0;
    wait_for(1, 100, "t2_idle");

    // 3: speed captured at grant, cfg change mid-frame applies next frame
    speed_log.delete();
    half_speed_cfg = 1; v[2] = 1; d[2] = 16'h1234; p[2] = 2'b01;
    wait_for(0, 20, "t3_load1");
    wait_for(3, 10, "t3_start");
    half_speed_cfg = 0; v[2] = 1; d[2] = 16'h4321;
    wait_for(1, 100, "t3_idle1");
    wait_for(0, 20, "t3_load2");
    tick();
    chk("t3_speed_frame1", speed_log[0], 1);
    chk("t3_speed_frame2", speed_log[1], 0);
    wait_for(1, 100, "t3_idle2");

    // 4: link never starts
    spi_dead = 1; v[1] = 1; d[1] = 16'h00FF;
    wait_for(0, 20, "t4_load");
    l0 = cyc;
    wait_for(2, 10, "t4_err");
    chk("t4_err_latency", cyc - l0, TO);
    t_err = cyc;
    wait_for(1, 20, "t4_idle");
    chk("t4_gap_after_err", cyc - t_err, GAP);
    err_clr = 1; tick(); err_clr = 0;
    chk("t4_err_cleared", start_err, 0);
    spi_dead = 0;

    // 5: reset during WAIT_DONE with requests pending
    v[2] = 1; d[2] = 16'hBEEF;
    wait_for(0, 20, "t5_load");
    wait_for(3, 10, "t5_start");
    repeat (3) tick();
    v[2] = 1; v[3] = 1; d[2] = 16'h2222; d[3] = 16'h3333;
    tick();
    reset_pulse();
    wait_for(0, 60, "t5_load_after_rst");
    chk("t5_grant_id", grant_id, 2);
    chk("t5_load_after_rise", cyc - csb_rise_cyc, GAP + 2);
    wait_for(1, 100, "t5_idle1");
    wait_for(0, 20, "t5_load3");
    wait_for(1, 100, "t5_idle2");
    v = '0;

    // 6: one-cycle request during WAIT_DONE is withdrawn
    v[0] = 1; d[0] = 16'h0F0F;
    wait_for(0, 20, "t6_load");
    wait_for(3, 10, "t6_start");
    tick();
    r1 = ready_cnt[1];
    v[1] = 1; d[1] = 16'h5555;
    tick();
    v[1] = 0;
    wait_for(1, 100, "t6_idle");
    l0 = load_cnt;
    repeat (10) tick();
    chk("t6_no_ready1", ready_cnt[1] - r1, 0);
    chk("t6_no_extra_load", load_cnt - l0, 0);

    // randomized traffic against the model
    rand_mode = 1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 1499) == 0) reset_pulse();
      else tick();
    end
    rand_mode = 0; spi_dead = 0; err_clr = 0; v = '0;
    wait_for(1, 200, "final_idle");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
